// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe
// Registered, handshaked control-decode stage sitting between instruction
// fetch and execute. The 5-bit opcode is turned into the CPU control bundle
// and held in a valid/ready pipeline register. The stage also supports a
// flush, multi-cycle occupancy for mul/div, flagging of the unassigned
// opcode and a sticky halt state.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   fetch-side handshake; instr/pc are the offered word
//   flush               drop the held instruction and any mul/div occupancy
//   out_valid/out_ready execute-side handshake for the registered bundle
//   out_instr, out_pc   registered copies of the accepted instr/pc
//   imm_sel .. call     decoded control fields (zero whenever out_valid=0)
//   illegal             the held opcode is the unassigned 0x0F
//   busy                a mul/div is occupying the stage
//   halted              a halt has been accepted; only rst clears this
module ctrl_decode_pipe #(
    parameter int INSTR_W    = 32,
    parameter int OPCODE_LSB = 27,
    parameter int PC_W       = 16,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         imm_sel,
    output logic [1:0]         reg_dst_sel,
    output logic [1:0]         sp_sel,
    output logic               branch_type,
    output logic               branch_sel,
    output logic               cmp,
    output logic               returni,
    output logic               mem_addr_sel,
    output logic               mem_wr,
    output logic               mem_rd,
    output logic               wb_sel,
    output logic               reg_wr,
    output logic               call,
    output logic               illegal,
    output logic               busy,
    output logic               halted
);

    localparam logic [4:0] OP_MUL  = 5'h06;
    localparam logic [4:0] OP_DIV  = 5'h08;
    localparam logic [4:0] OP_HALT = 5'h1F;

    // Counter preload values: the accept edge itself is the first cycle of
    // occupancy, so the counter starts at L-1 and releases when it reads 1.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MULTI  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] imm_sel;
        logic [1:0] reg_dst_sel;
        logic [1:0] sp_sel;
        logic       branch_type;
        logic       branch_sel;
        logic       cmp;
        logic       returni;
        logic       mem_addr_sel;
        logic       mem_wr;
        logic       mem_rd;
        logic       wb_sel;
        logic       reg_wr;
        logic       call;
        logic       illegal;
    } ctrl_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               valid_q;
    ctrl_t              out_ctrl;
    logic [INSTR_W-1:0] out_instr_q;
    logic [PC_W-1:0]    out_pc_q;

    // A mul/div parks its bundle here while it occupies the stage, so the
    // visible output register stays a cleared bubble until it completes.
    ctrl_t              pend_ctrl;
    logic [INSTR_W-1:0] pend_instr;
    logic [PC_W-1:0]    pend_pc;

    logic [4:0]         opcode;
    ctrl_t              dec;
    logic               accept;
    logic               consume;
    logic               is_multi;
    logic [CNT_W-1:0]   multi_load;

    assign opcode = instr[OPCODE_LSB +: 5];

    // Opcode to control-bundle mapping. Anything not listed (nop, halt)
    // leaves every field at zero; 0x0F additionally raises illegal.
    always_comb begin
        dec = '0;
        case (opcode)
            5'h02, 5'h04, 5'h06, 5'h08, 5'h0A, 5'h0C, 5'h10: begin
                dec.reg_dst_sel = 2'b10;
                dec.reg_wr      = 1'b1;
            end
            5'h03, 5'h05, 5'h0B, 5'h0D, 5'h11: begin
                dec.imm_sel     = 2'b01;
                dec.reg_dst_sel = 2'b01;
                dec.reg_wr      = 1'b1;
            end
            5'h0E: begin
                dec.reg_dst_sel = 2'b01;
                dec.reg_wr      = 1'b1;
            end
            5'h07, 5'h1E: begin
                dec.reg_wr = 1'b1;
            end
            5'h01: begin
                dec.reg_dst_sel  = 2'b10;
                dec.mem_addr_sel = 1'b1;
                dec.sp_sel       = 2'b10;
                dec.mem_rd       = 1'b1;
                dec.wb_sel       = 1'b1;
                dec.reg_wr       = 1'b1;
            end
            5'h09: begin
                dec.mem_addr_sel = 1'b1;
                dec.sp_sel       = 2'b01;
                dec.mem_wr       = 1'b1;
            end
            5'h12: begin
                dec.cmp = 1'b1;
            end
            5'h13, 5'h14, 5'h15, 5'h16, 5'h18: begin
                dec.imm_sel     = 2'b10;
                dec.branch_type = 1'b1;
                dec.branch_sel  = 1'b1;
            end
            5'h17: begin
                dec.imm_sel    = 2'b10;
                dec.branch_sel = 1'b1;
            end
            5'h19: begin
                dec.branch_type = 1'b1;
                dec.branch_sel  = 1'b1;
                dec.reg_wr      = 1'b1;
                dec.call        = 1'b1;
            end
            5'h1A: begin
                dec.branch_sel = 1'b1;
            end
            5'h1B: begin
                dec.returni = 1'b1;
            end
            5'h1C: begin
                dec.imm_sel = 2'b01;
                dec.mem_wr  = 1'b1;
            end
            5'h1D: begin
                dec.reg_dst_sel = 2'b01;
                dec.mem_rd      = 1'b1;
                dec.wb_sel      = 1'b1;
                dec.reg_wr      = 1'b1;
            end
            5'h0F: begin
                dec.illegal = 1'b1;
            end
            default: begin
                dec = '0;
            end
        endcase
    end

    // Ready depends combinationally on out_ready so a continuously drained
    // stage sustains one instruction per cycle.
    assign in_ready = (state == RUN) && !flush && !rst && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;

    // Only mul/div with an occupancy above one cycle take the MULTI path;
    // a one-cycle setting falls through to the ordinary single-cycle path.
    assign is_multi = ((opcode == OP_MUL) && (MUL_CYCLES > 1)) ||
                      ((opcode == OP_DIV) && (DIV_CYCLES > 1));
    assign multi_load = (opcode == OP_MUL) ? MUL_LOAD : DIV_LOAD;

    // Stage state machine and pipeline register. Flush takes priority over
    // everything except reset, and leaves HALTED in place. Every path that
    // drops out_valid also clears the bundle so bubbles read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            valid_q     <= 1'b0;
            out_ctrl    <= '0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            pend_ctrl   <= '0;
            pend_instr  <= '0;
            pend_pc     <= '0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            out_ctrl    <= '0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            cnt         <= '0;
            if (state == MULTI) begin
                state <= RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        if (is_multi) begin
                            pend_ctrl   <= dec;
                            pend_instr  <= instr;
                            pend_pc     <= pc;
                            cnt         <= multi_load;
                            valid_q     <= 1'b0;
                            out_ctrl    <= '0;
                            out_instr_q <= '0;
                            out_pc_q    <= '0;
                            state       <= MULTI;
                        end else begin
                            out_ctrl    <= dec;
                            out_instr_q <= instr;
                            out_pc_q    <= pc;
                            valid_q     <= 1'b1;
                            if (opcode == OP_HALT) begin
                                state <= HALTED;
                            end
                        end
                    end else if (consume) begin
                        valid_q     <= 1'b0;
                        out_ctrl    <= '0;
                        out_instr_q <= '0;
                        out_pc_q    <= '0;
                    end
                end
                MULTI: begin
                    if (cnt == CNT_ONE) begin
                        out_ctrl    <= pend_ctrl;
                        out_instr_q <= pend_instr;
                        out_pc_q    <= pend_pc;
                        valid_q     <= 1'b1;
                        cnt         <= '0;
                        state       <= RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HALTED: begin
                    if (consume) begin
                        valid_q     <= 1'b0;
                        out_ctrl    <= '0;
                        out_instr_q <= '0;
                        out_pc_q    <= '0;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign out_valid    = valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign imm_sel      = out_ctrl.imm_sel;
    assign reg_dst_sel  = out_ctrl.reg_dst_sel;
    assign sp_sel       = out_ctrl.sp_sel;
    assign branch_type  = out_ctrl.branch_type;
    assign branch_sel   = out_ctrl.branch_sel;
    assign cmp          = out_ctrl.cmp;
    assign returni      = out_ctrl.returni;
    assign mem_addr_sel = out_ctrl.mem_addr_sel;
    assign mem_wr       = out_ctrl.mem_wr;
    assign mem_rd       = out_ctrl.mem_rd;
    assign wb_sel       = out_ctrl.wb_sel;
    assign reg_wr       = out_ctrl.reg_wr;
    assign call         = out_ctrl.call;
    assign illegal      = out_ctrl.illegal;
    assign busy         = (state == MULTI);
    assign halted       = (state == HALTED);

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe
// Self-checking bench for ctrl_decode_pipe. A behavioural model tracks what
// the stage should hold (an instruction, how many cycles until it becomes
// visible, and whether a halt was taken) and derives every expected output
// from the decode table and handshake rules.
module tb_ctrl_decode_pipe;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_LSB = 27;
    localparam int PC_W       = 16;
    localparam int MUL_CYCLES = 2;
    localparam int DIV_CYCLES = 8;
    localparam int CNT_W      = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [1:0]         imm_sel;
    logic [1:0]         reg_dst_sel;
    logic [1:0]         sp_sel;
    logic               branch_type;
    logic               branch_sel;
    logic               cmp;
    logic               returni;
    logic               mem_addr_sel;
    logic               mem_wr;
    logic               mem_rd;
    logic               wb_sel;
    logic               reg_wr;
    logic               call;
    logic               illegal;
    logic               busy;
    logic               halted;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: what the stage holds and when it becomes visible.
    bit                 m_has;
    bit                 m_halted;
    int                 m_remain;
    bit                 m_acc;
    logic [INSTR_W-1:0] m_instr;
    logic [PC_W-1:0]    m_pc;

    ctrl_decode_pipe #(
        .INSTR_W(INSTR_W), .OPCODE_LSB(OPCODE_LSB), .PC_W(PC_W),
        .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .imm_sel(imm_sel), .reg_dst_sel(reg_dst_sel), .sp_sel(sp_sel),
        .branch_type(branch_type), .branch_sel(branch_sel), .cmp(cmp),
        .returni(returni), .mem_addr_sel(mem_addr_sel), .mem_wr(mem_wr),
        .mem_rd(mem_rd), .wb_sel(wb_sel), .reg_wr(reg_wr), .call(call),
        .illegal(illegal), .busy(busy), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control vector for an opcode, built from the instruction
    // classes rather than a per-opcode encoding.
    function automatic logic [16:0] model_ctrl(input logic [4:0] op);
        logic [1:0] imm, dst, sp;
        logic bt, bs, cm, ri, mas, mw, mr, wb, rw, cl, il;
        {imm, dst, sp} = '0;
        {bt, bs, cm, ri, mas, mw, mr, wb, rw, cl, il} = '0;
        if (op inside {5'h02, 5'h04, 5'h06, 5'h08, 5'h0A, 5'h0C, 5'h10}) begin
            dst = 2'b10; rw = 1'b1;
        end
        if (op inside {5'h03, 5'h05, 5'h0B, 5'h0D, 5'h11}) begin
            imm = 2'b01; dst = 2'b01; rw = 1'b1;
        end
        if (op == 5'h0E) begin dst = 2'b01; rw = 1'b1; end
        if (op inside {5'h07, 5'h1E}) rw = 1'b1;
        if (op == 5'h01) begin
            dst = 2'b10; mas = 1'b1; sp = 2'b10; mr = 1'b1; wb = 1'b1; rw = 1'b1;
        end
        if (op == 5'h09) begin mas = 1'b1; sp = 2'b01; mw = 1'b1; end
        if (op == 5'h12) cm = 1'b1;
        if (op inside {5'h13, 5'h14, 5'h15, 5'h16, 5'h18}) begin
            imm = 2'b10; bt = 1'b1; bs = 1'b1;
        end
        if (op == 5'h17) begin imm = 2'b10; bs = 1'b1; end
        if (op == 5'h19) begin bt = 1'b1; bs = 1'b1; rw = 1'b1; cl = 1'b1; end
        if (op == 5'h1A) bs = 1'b1;
        if (op == 5'h1B) ri = 1'b1;
        if (op == 5'h1C) begin imm = 2'b01; mw = 1'b1; end
        if (op == 5'h1D) begin dst = 2'b01; mr = 1'b1; wb = 1'b1; rw = 1'b1; end
        if (op == 5'h0F) il = 1'b1;
        return {imm, dst, sp, bt, bs, cm, ri, mas, mw, mr, wb, rw, cl, il};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [4:0] op, input bit ordy,
                                 input bit fl, input bit rs);
        logic [INSTR_W-1:0] w;
        w = $urandom;
        w[OPCODE_LSB +: 5] = op;
        in_valid  = v;
        instr     = w;
        pc        = PC_W'($urandom);
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
    endtask

    task automatic checkOutput(input string tag, input bit exp_rdy, input bit exp_vld);
        logic [16:0] obs_ctrl;
        logic [16:0] exp_ctrl;
        obs_ctrl = {imm_sel, reg_dst_sel, sp_sel, branch_type, branch_sel, cmp,
                    returni, mem_addr_sel, mem_wr, mem_rd, wb_sel, reg_wr, call, illegal};
        exp_ctrl = exp_vld ? model_ctrl(m_instr[OPCODE_LSB +: 5]) : 17'd0;
        chk({tag, ".in_ready"},  64'(in_ready),  64'(exp_rdy));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_vld));
        chk({tag, ".busy"},      64'(busy),      64'(m_has && m_remain > 0));
        chk({tag, ".halted"},    64'(halted),    64'(m_halted));
        chk({tag, ".ctrl"},      64'(obs_ctrl),  64'(exp_ctrl));
        if (exp_vld) begin
            chk({tag, ".out_pc"},    64'(out_pc),    64'(m_pc));
            chk({tag, ".out_instr"}, 64'(out_instr), 64'(m_instr));
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the
    // coming rising edge using the same inputs the DUT will sample.
    task automatic cycle(input string tag);
        bit rdy, vld;
        logic [4:0] op;
        @(negedge clk);
        rdy = !m_halted && !flush && !rst && (!m_has || (m_remain == 0 && out_ready));
        vld = m_has && (m_remain == 0);
        checkOutput(tag, rdy, vld);
        m_acc = in_valid && rdy;
        if (rst) begin
            m_has = 0; m_remain = 0; m_halted = 0;
        end else if (flush) begin
            m_has = 0; m_remain = 0;
        end else if (m_has && m_remain > 0) begin
            m_remain--;
        end else begin
            if (vld && out_ready) m_has = 0;
            if (m_acc) begin
                m_has   = 1;
                m_instr = instr;
                m_pc    = pc;
                op      = instr[OPCODE_LSB +: 5];
                m_remain = (op == 5'h06) ? MUL_CYCLES - 1 :
                           (op == 5'h08) ? DIV_CYCLES - 1 : 0;
                if (op == 5'h1F) m_halted = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction and keep it steady until the model says it was
    // taken; a stage that never takes it is reported and the run moves on.
    task automatic offer(input logic [4:0] op, input string tag);
        int tries;
        applyStimulus(1'b1, op, 1'b1, 1'b0, 1'b0);
        tries = 0;
        do begin
            cycle(tag);
            tries++;
        end while (!m_acc && tries < 40);
        if (!m_acc) chk({tag, ".accept_timeout"}, 64'(m_acc), 64'd1);
    endtask

    initial begin
        m_has = 0; m_halted = 0; m_remain = 0; m_acc = 0;
        m_instr = '0; m_pc = '0;
        applyStimulus(1'b0, 5'h00, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with valid offered to show it is refused.
        applyStimulus(1'b1, 5'h02, 1'b1, 1'b0, 1'b1);
        cycle("reset");
        chk("reset.out_pc", 64'(out_pc), 64'd0);
        chk("reset.out_instr", 64'(out_instr), 64'd0);

        // Every opcode in order, halt last.
        for (int op = 0; op < 32; op++) offer(5'(op), $sformatf("stream%02h", op));

        // Halt drains, add stays refused, flush keeps halted, rst clears it.
        applyStimulus(1'b1, 5'h02, 1'b1, 1'b0, 1'b0);
        repeat (4) cycle("halted");
        flush = 1'b1;
        cycle("halted_flush");
        flush = 1'b0;
        repeat (2) cycle("halted_after_flush");
        rst = 1'b1;
        cycle("halted_rst");
        rst = 1'b0;
        cycle("after_rst");

        // Back-pressure: add held for three cycles, sub waits then goes.
        applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
        cycle("idle");
        offer(5'h02, "stall_add");
        applyStimulus(1'b1, 5'h04, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle("stall_hold");
        out_ready = 1'b1;
        cycle("stall_release");
        chk("stall_release.accepted", 64'(m_acc), 64'd1);

        // div occupancy with the next instruction waiting.
        offer(5'h08, "div");
        offer(5'h02, "after_div");

        // mul in its last occupancy cycle, killed by flush with valid high.
        offer(5'h06, "mul");
        applyStimulus(1'b1, 5'h02, 1'b1, 1'b1, 1'b0);
        cycle("mul_flush");
        flush = 1'b0;
        cycle("post_flush");

        // pop immediately followed by push, no bubble.
        offer(5'h01, "pop");
        offer(5'h09, "push");
        applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle("pop_push_drain");

        // Randomized traffic with back-pressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 30)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, 1'b0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Registered, handshaked control-decode stage between instruction fetch and execute. It maps the 5-bit opcode to the CPU control bundle and holds the result in a valid/ready pipeline register. It also provides flush, multi-cycle occupancy for mul/div, illegal-opcode flagging and a sticky halt state. It supersedes the purely combinational opcode decoder in the CPU datapath.

## Interface
- INSTR_W, 32: instruction width.
- OPCODE_LSB, 27: the opcode is instr[OPCODE_LSB+4:OPCODE_LSB].
- PC_W, 16: PC width.
- MUL_CYCLES, 2: stage occupancy for mul, in cycles. Range 1..2^CNT_W-1.
- DIV_CYCLES, 8: stage occupancy for div, in cycles. Same range.
- CNT_W, 4: occupancy counter width.

Ports:
- clk  in  1  clock. Rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers instr/pc.
- in_ready  out  1  stage accepts this cycle.
- instr  in  INSTR_W  instruction word.
- pc  in  PC_W  instruction address.
- flush  in  1  kill the held instruction and any occupancy.
- out_valid  out  1  registered bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_instr, out_pc  out  INSTR_W, PC_W  registered copies of the inputs.
- imm_sel, reg_dst_sel, sp_sel  out  2 each  control fields.
- branch_type, branch_sel, cmp, returni, mem_addr_sel, mem_wr, mem_rd, wb_sel, reg_wr, call  out  1 each  control bits.
- illegal  out  1  the held opcode is unassigned (0x0F).
- busy  out  1  FSM is in MULTI.
- halted  out  1  FSM is in HALTED.

## Operation
- Decode. Every field is 0 unless listed below.
  - Register ALU ops (add 02, sub 04, mul 06, div 08, and 0A, or 0C, xor 10): reg_dst_sel=10, reg_wr=1.
  - Immediate ALU ops (addi 03, subi 05, andi 0B, ori 0D, xori 11): imm_sel=01, reg_dst_sel=01, reg_wr=1.
  - not 0E: reg_dst_sel=01, reg_wr=1.
  - moveh 07, movel 1E: reg_wr=1.
  - pop 01: reg_dst_sel=10, mem_addr_sel=1, sp_sel=10, mem_rd=1, wb_sel=1, reg_wr=1.
  - push 09: mem_addr_sel=1, sp_sel=01, mem_wr=1.
  - cmp 12: cmp=1.
  - beq 13, blt 14, bgt 15, bne 16, jumprel 18: imm_sel=10, branch_type=1, branch_sel=1.
  - jump 17: imm_sel=10, branch_sel=1.
  - call 19: branch_type=1, branch_sel=1, reg_wr=1, call=1.
  - return 1A: branch_sel=1.
  - returni 1B: returni=1.
  - store 1C: imm_sel=01, mem_wr=1.
  - load 1D: reg_dst_sel=01, mem_rd=1, wb_sel=1, reg_wr=1.
  - nop 00, halt 1F: all zero.
  - 0F: all zero with illegal=1.
- Handshake:
  - in_ready = (state==RUN) && !flush && !rst && (!out_valid || out_ready).
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - While out_valid && !out_ready, all outputs hold stable.
- Bubbles: whenever out_valid=0, every control output and illegal read 0; the register is cleared, not gated.
- FSM states: RUN, MULTI, HALTED.
  - RUN, on accept of mul/div with L>1 (L = MUL_CYCLES or DIV_CYCLES): load the bundle, cnt=L-1, out_valid=0, go to MULTI.
  - RUN, on accept of halt: load the zero bundle, out_valid=1, go to HALTED.
  - RUN, on any other accept: out_valid=1.
  - RUN, no accept and output consumed: out_valid=0.
  - MULTI: in_ready=0. If cnt==1: out_valid=1, go to RUN. Otherwise cnt decrements.
  - HALTED: in_ready=0, halted=1. The halt bundle drains normally on out_ready. Only rst leaves HALTED.
- Flush, on the same edge:
  - out_valid=0, bundle cleared, cnt=0.
  - MULTI goes to RUN. HALTED is unaffected.
  - Flush overrides a simultaneous accept; in_ready is already low.
- Reset: state=RUN, cnt=0. All outputs are 0, including out_valid, busy, halted, illegal, out_instr and out_pc.

## Timing
- Single-cycle ops: accepted at edge k, out_valid=1 after edge k.
- mul/div: accepted at edge k; busy=1 from edge k to edge k+L-1; out_valid=1 after edge k+L-1.
- L=1 behaves exactly as a single-cycle op.
- Throughput is one instruction per cycle when out_ready is held high (in_ready depends combinationally on out_ready).
- Reset asserted during MULTI or HALTED takes effect at the next edge; the pending bundle is lost.

## Test plan
- Reset, then stream all 32 opcodes with out_ready=1: each bundle appears 1 cycle after acceptance and matches the decode list; opcode 0x0F gives illegal=1 with all controls 0.
- add accepted, out_ready=0 for 3 cycles: out_valid, the bundle and out_pc stay stable; in_ready=0; next instruction accepted on the cycle out_ready returns.
- div with DIV_CYCLES=8 accepted at edge 0: busy=1 on edges 0..7, in_ready=0, out_valid=1 after edge 7 with reg_dst_sel=10, reg_wr=1.
- mul in MULTI with cnt=1, flush asserted with in_valid=1: next cycle out_valid=0, busy=0, state RUN, no instruction accepted that cycle.
- halt followed by add on in_valid: halt bundle delivered (all zero, out_valid=1); halted=1; in_ready stays 0 permanently; flush does not clear halted; rst returns in_ready=1 and halted=0.
- pop with out_ready=1 back-to-back with push: consecutive cycles show sp_sel 10 then 01, mem_rd then mem_wr; no bubble between them.
